// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of a multiplexed 8-digit 7-segment bus.
// Waits for each digit's pattern to hold steady, decodes it back to a hex
// nibble with dp/blank/err flags, and publishes a 32-bit frame once all
// eight digits have been seen.
module seg_scan_capture #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_n,
    input  logic [7:0]  an_n,
    output logic        frame_valid,
    output logic [31:0] frame_hex,
    output logic [7:0]  frame_dp,
    output logic [7:0]  frame_blank,
    output logic [7:0]  frame_err,
    output logic [3:0]  digit_cnt
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

    state_t      state_q, state_d;
    logic [15:0] in_q, prev_q;
    logic [7:0]  stab_q, stab_d;
    logic [31:0] slot_hex_q;
    logic [7:0]  slot_dp_q, slot_blank_q, slot_err_q;
    logic [7:0]  seen_q, seen_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        frame_valid_q;
    logic [31:0] frame_hex_q;
    logic [7:0]  frame_dp_q, frame_blank_q, frame_err_q;

    logic [7:0]  an_low;
    logic        an_valid;
    logic [2:0]  digit_idx;
    logic        changed;
    logic        capture;
    logic        publish;
    logic [6:0]  lit;
    logic [3:0]  enc_nib;
    logic        enc_blank, enc_err;

    // Anode decode: one-cold check and index of the selected digit.
    always_comb begin
        an_low    = ~in_q[15:8];
        an_valid  = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
        digit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) digit_idx = 3'(i);
        end
        changed   = (in_q != prev_q);
    end

    // Stability counter: restarts on any change, saturates at SETTLE.
    always_comb begin
        stab_d = stab_q;
        if (!an_valid)              stab_d = 8'd0;
        else if (changed)           stab_d = 8'd1;
        else if (stab_q < SETTLE_CNT) stab_d = stab_q + 8'd1;
    end

    // Capture fires on the sample that completes the settle window; once
    // HELD, only a change of the bus can arm another capture.
    always_comb begin
        capture = an_valid && (stab_d == SETTLE_CNT) &&
                  ((state_q != S_HELD) || changed);
        state_d = S_SETTLE;
        if (!an_valid)                          state_d = S_IDLE;
        else if (capture)                       state_d = S_HELD;
        else if (state_q == S_HELD && !changed) state_d = S_HELD;
    end

    // Segment pattern back to hex glyph; anything else is blank or error.
    always_comb begin
        lit       = ~in_q[6:0];
        enc_nib   = 4'h0;
        enc_blank = 1'b0;
        enc_err   = 1'b0;
        case (lit)
            7'h3F: enc_nib = 4'h0;
            7'h06: enc_nib = 4'h1;
            7'h5B: enc_nib = 4'h2;
            7'h4F: enc_nib = 4'h3;
            7'h66: enc_nib = 4'h4;
            7'h6D: enc_nib = 4'h5;
            7'h7D: enc_nib = 4'h6;
            7'h07: enc_nib = 4'h7;
            7'h7F: enc_nib = 4'h8;
            7'h6F: enc_nib = 4'h9;
            7'h77: enc_nib = 4'hA;
            7'h7C: enc_nib = 4'hB;
            7'h39: enc_nib = 4'hC;
            7'h5E: enc_nib = 4'hD;
            7'h79: enc_nib = 4'hE;
            7'h71: enc_nib = 4'hF;
            7'h00: enc_blank = 1'b1;
            default: enc_err = 1'b1;
        endcase
    end

    // Seen mask clears on publish; a capture in the same cycle still counts.
    always_comb begin
        publish = (seen_q == 8'hFF);
        seen_d  = publish ? 8'd0 : seen_q;
        if (capture) seen_d[digit_idx] = 1'b1;
        cnt_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt_d = cnt_d + 4'(seen_d[i]);
        end
    end

    // Input register and its one-cycle history.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= 16'd0;
            prev_q <= 16'd0;
        end else begin
            in_q   <= {an_n, seg_n};
            prev_q <= in_q;
        end
    end

    // Capture FSM and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stab_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
        end
    end

    // Working slots: a capture overwrites the selected digit's entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_hex_q   <= 32'd0;
            slot_dp_q    <= 8'd0;
            slot_blank_q <= 8'd0;
            slot_err_q   <= 8'd0;
        end else if (capture) begin
            slot_hex_q[{digit_idx, 2'b00} +: 4] <= enc_nib;
            slot_dp_q[digit_idx]    <= ~in_q[7];
            slot_blank_q[digit_idx] <= enc_blank;
            slot_err_q[digit_idx]   <= enc_err;
        end
    end

    // Seen mask and its registered population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 8'd0;
            cnt_q  <= 4'd0;
        end else begin
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    // Published frame: loads all slots one cycle after the completing capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_q <= 1'b0;
            frame_hex_q   <= 32'd0;
            frame_dp_q    <= 8'd0;
            frame_blank_q <= 8'd0;
            frame_err_q   <= 8'd0;
        end else begin
            frame_valid_q <= publish;
            if (publish) begin
                frame_hex_q   <= slot_hex_q;
                frame_dp_q    <= slot_dp_q;
                frame_blank_q <= slot_blank_q;
                frame_err_q   <= slot_err_q;
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_hex   = frame_hex_q;
    assign frame_dp    = frame_dp_q;
    assign frame_blank = frame_blank_q;
    assign frame_err   = frame_err_q;
    assign digit_cnt   = cnt_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture (SETTLE = 4). Inputs change on the
// falling edge; outputs are checked on the falling edge.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_n = 8'hFF;
    logic [7:0]  an_n  = 8'hFF;
    logic        frame_valid;
    logic [31:0] frame_hex;
    logic [7:0]  frame_dp, frame_blank, frame_err;
    logic [3:0]  digit_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    seg_scan_capture #(.SETTLE(4)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .frame_valid(frame_valid), .frame_hex(frame_hex),
        .frame_dp(frame_dp), .frame_blank(frame_blank),
        .frame_err(frame_err), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    // Count publish pulses shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) pulses++;
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] v, input logic dp);
        seg_of = {~dp, ~glyph(v)};
    endfunction

    // Called at a falling edge; drives one digit for cyc cycles.
    task automatic show(input int idx, input logic [7:0] seg, input int cyc);
        an_n  = ~(8'b1 << idx);
        seg_n = seg;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic idle(input int cyc);
        an_n  = 8'hFF;
        seg_n = 8'hFF;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [31:0] hex, input int cyc);
        for (int i = 0; i < 8; i++) show(i, seg_of(hex[4*i +: 4], 1'b0), cyc);
        idle(3);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_tests++; if (frame_hex !== 32'h0) begin n_fail++; $display("FAIL reset_hex: got %h want 0", frame_hex); end
        n_tests++; if (frame_dp !== 8'h0 || frame_blank !== 8'h0 || frame_err !== 8'h0) begin
            n_fail++; $display("FAIL reset_flags: got dp=%h blank=%h err=%h want 0", frame_dp, frame_blank, frame_err); end
        // A settled digit while reset is held must not be captured.
        show(0, seg_of(4'h7, 1'b0), 8);
        n_tests++; if (digit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", digit_cnt); end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_frame;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 5; i++) show(i, seg_of(4'(8 - i), 1'b0), 6);
        n_tests++; if (digit_cnt !== 4'd5) begin n_fail++; $display("FAIL frame_partial_cnt: got %0d want 5", digit_cnt); end
        n_tests++; if (pulses != p0) begin n_fail++; $display("FAIL frame_early: got %0d pulses want 0", pulses - p0); end
        for (int i = 5; i < 8; i++) show(i, seg_of(4'(8 - i), 1'b0), 6);
        idle(3);
        n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL frame_pulse: got %0d want 1", pulses - p0); end
        n_tests++; if (frame_hex !== 32'h12345678) begin n_fail++; $display("FAIL frame_hex: got %h want 12345678", frame_hex); end
        n_tests++; if (frame_dp !== 8'h0 || frame_blank !== 8'h0 || frame_err !== 8'h0) begin
            n_fail++; $display("FAIL frame_flags: got dp=%h blank=%h err=%h want 0", frame_dp, frame_blank, frame_err); end
        n_tests++; if (digit_cnt !== 4'd0) begin n_fail++; $display("FAIL frame_cnt: got %0d want 0", digit_cnt); end
    endtask

    // A digit held 3 cycles is too short; 4 cycles captures on the 5th edge.
    task automatic test_latency;
        int p0;
        p0 = pulses;
        show(1, seg_of(4'h9, 1'b0), 3);
        idle(4);
        n_tests++; if (digit_cnt !== 4'd0) begin n_fail++; $display("FAIL lat_short: got %0d want 0", digit_cnt); end
        show(1, seg_of(4'h9, 1'b0), 4);
        n_tests++; if (digit_cnt !== 4'd0) begin n_fail++; $display("FAIL lat_early: got %0d want 0", digit_cnt); end
        idle(1);
        n_tests++; if (digit_cnt !== 4'd1) begin n_fail++; $display("FAIL lat_edge: got %0d want 1", digit_cnt); end
        idle(2);
        show(0, seg_of(4'h8, 1'b0), 5);
        for (int i = 2; i < 8; i++) show(i, seg_of(4'(8 - i), 1'b0), 5);
        idle(3);
        n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL lat_pulse: got %0d want 1", pulses - p0); end
        n_tests++; if (frame_hex !== 32'h12345698) begin n_fail++; $display("FAIL lat_hex: got %h want 12345698", frame_hex); end
    endtask

    task automatic test_flags;
        logic [7:0] seg;
        for (int i = 0; i < 8; i++) begin
            seg = seg_of(4'(8 - i), 1'b0);
            if (i == 3) seg = 8'h7F;
            if (i == 5) seg = 8'hB6;
            show(i, seg, 6);
        end
        idle(3);
        n_tests++; if (frame_hex !== 32'h12040678) begin n_fail++; $display("FAIL flags_hex: got %h want 12040678", frame_hex); end
        n_tests++; if (frame_blank !== 8'h08) begin n_fail++; $display("FAIL flags_blank: got %h want 08", frame_blank); end
        n_tests++; if (frame_err !== 8'h20) begin n_fail++; $display("FAIL flags_err: got %h want 20", frame_err); end
        n_tests++; if (frame_dp !== 8'h08) begin n_fail++; $display("FAIL flags_dp: got %h want 08", frame_dp); end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = pulses;
        show(0, seg_of(4'h8, 1'b0), 6);
        show(1, seg_of(4'h7, 1'b0), 6);
        show(2, seg_of(4'h6, 1'b0), 6);
        show(2, seg_of(4'hF, 1'b0), 3);
        show(2, seg_of(4'h6, 1'b0), 6);
        n_tests++; if (digit_cnt !== 4'd3) begin n_fail++; $display("FAIL glitch_cnt: got %0d want 3", digit_cnt); end
        for (int i = 3; i < 8; i++) show(i, seg_of(4'(8 - i), 1'b0), 6);
        idle(3);
        n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL glitch_pulse: got %0d want 1", pulses - p0); end
        n_tests++; if (frame_hex !== 32'h12345678) begin n_fail++; $display("FAIL glitch_hex: got %h want 12345678", frame_hex); end
    endtask

    task automatic test_multi_low;
        int p0;
        p0 = pulses;
        show(0, seg_of(4'h1, 1'b0), 6);
        show(1, seg_of(4'h2, 1'b0), 6);
        an_n  = 8'hFC;
        seg_n = seg_of(4'h3, 1'b0);
        repeat (20) @(negedge clk);
        n_tests++; if (digit_cnt !== 4'd2) begin n_fail++; $display("FAIL multi_cnt: got %0d want 2", digit_cnt); end
        n_tests++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL multi_state: got %0d want 0", dut.state_q); end
        n_tests++; if (pulses != p0) begin n_fail++; $display("FAIL multi_pulse: got %0d want 0", pulses - p0); end
        idle(2);
    endtask

    task automatic test_reset_mid;
        int p0;
        show(2, seg_of(4'h3, 1'b0), 6);
        show(3, seg_of(4'h4, 1'b0), 6);
        show(4, seg_of(4'h5, 1'b0), 6);
        n_tests++; if (digit_cnt !== 4'd5) begin n_fail++; $display("FAIL rmid_before: got %0d want 5", digit_cnt); end
        idle(1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (digit_cnt !== 4'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 0", digit_cnt); end
        n_tests++; if (frame_hex !== 32'h0) begin n_fail++; $display("FAIL rmid_hex: got %h want 0", frame_hex); end
        p0 = pulses;
        for (int i = 5; i < 8; i++) show(i, seg_of(4'(8 + i), 1'b0), 6);
        idle(3);
        n_tests++; if (digit_cnt !== 4'd3 || pulses != p0) begin
            n_fail++; $display("FAIL rmid_partial: got cnt=%0d pulses=%0d want cnt=3 pulses=0", digit_cnt, pulses - p0); end
        for (int i = 0; i < 5; i++) show(i, seg_of(4'(8 + i), 1'b0), 6);
        idle(3);
        n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL rmid_pulse: got %0d want 1", pulses - p0); end
        n_tests++; if (frame_hex !== 32'hFEDCBA98) begin n_fail++; $display("FAIL rmid_hex2: got %h want FEDCBA98", frame_hex); end
    endtask

    task automatic test_glyphs;
        for (int v = 0; v < 16; v++) begin
            scan_frame(32'(v), 6);
            n_tests++; if (frame_hex !== 32'(v)) begin n_fail++; $display("FAIL glyph_%0d_hex: got %h want %h", v, frame_hex, 32'(v)); end
            n_tests++; if (frame_err !== 8'h0) begin n_fail++; $display("FAIL glyph_%0d_err: got %h want 0", v, frame_err); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_latency();
        test_flags();
        test_glitch();
        test_multi_low();
        test_reset_mid();
        test_glyphs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
